// File: rtl/fp16_vec64_packer_pkg.sv
// Shared definitions for the FP16 64-lane vector packer.
//   FP16_DW       element width (FP16 bit pattern)
//   MAX_LANES     lanes per packed vector
//   FP16_NEG_INF  FP16 -inf, used as the pad value for unused lanes
//   state_t       packer FSM states (COLLECT / HOLD)
package fp16_vec64_packer_pkg;

  localparam int unsigned FP16_DW      = 16;
  localparam int unsigned MAX_LANES    = 64;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/fp16_pack_ctrl.sv
// Control path of the FP16 vector packer: FSM, lane counter, framing check
// and pad mask.
// Optional feature macro: FP16_PACK_PAD_EN (early s_tlast completes the vector
// and pads the remaining lanes).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   s_tvalid      element valid
//   s_tlast       element marks end of vector
//   m_x_ready     consumer ready for the held vector
//   s_tready      element accept enable (COLLECT)
//   m_x_valid     vector held and valid (HOLD)
//   wr_en/wr_idx  lane write strobe and lane index for the current element
//   pad_mask      lanes to load with the pad value on this edge
//   lanes_used    number of real lanes in the held vector
//   frame_err     one-cycle pulse on s_tlast / count mismatch
module fp16_pack_ctrl
  import fp16_vec64_packer_pkg::*;
#(
  parameter  int unsigned N_LANES = MAX_LANES,
  localparam int unsigned IW      = $clog2(N_LANES),
  localparam int unsigned LW      = IW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  input  logic               m_x_ready,
  output logic               s_tready,
  output logic               m_x_valid,
  output logic               wr_en,
  output logic [IW-1:0]      wr_idx,
  output logic [N_LANES-1:0] pad_mask,
  output logic [LW-1:0]      lanes_used,
  output logic               frame_err
);

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [LW-1:0] used_nx;
  logic          ferr_nx;
  logic          last_slot;
`ifdef FP16_PACK_PAD_EN
  logic          early_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_COLLECT;
      idx        <= '0;
      lanes_used <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      lanes_used <= used_nx;
      frame_err  <= ferr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    used_nx   = lanes_used;
    ferr_nx   = 1'b0;
    pad_mask  = '0;
    s_tready  = (state == ST_COLLECT);
    m_x_valid = (state == ST_HOLD);
    wr_en     = s_tvalid && s_tready;
    wr_idx    = idx;
    last_slot = (idx == IW'(N_LANES - 1));

    case (state)
      ST_COLLECT: begin
        if (wr_en) begin
          idx_nx = idx + IW'(1);
          if (last_slot) begin
            state_nx = ST_HOLD;
            used_nx  = LW'(N_LANES);
            idx_nx   = '0;
          end
`ifdef FP16_PACK_PAD_EN
          else if (s_tlast) begin
            state_nx = ST_HOLD;
            used_nx  = {1'b0, idx} + LW'(1);
            idx_nx   = '0;
          end
          ferr_nx = !s_tlast && last_slot;
`else
          ferr_nx = (s_tlast != last_slot);
`endif
        end
      end
      ST_HOLD: begin
        if (m_x_ready) begin
          state_nx = ST_COLLECT;
          idx_nx   = '0;
        end
      end
      default: state_nx = ST_COLLECT;
    endcase

`ifdef FP16_PACK_PAD_EN
    // Every lane above the final real element is padded on the completing edge.
    early_last = wr_en && s_tlast && !last_slot;
    for (int unsigned k = 0; k < N_LANES; k++) begin
      pad_mask[k] = early_last && (IW'(k) > idx);
    end
`endif
  end

endmodule

// File: rtl/fp16_vec64_packer.sv
// Collects a serial FP16 stream (valid/ready/last) into an N_LANES x DW vector
// and presents it on a wide bus with valid/ready; the vector is held stable
// until the consumer accepts it.
// Optional feature macro: FP16_PACK_PAD_EN (early s_tlast pads lanes with
// PAD_VALUE and completes the vector).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   s_tdata       serial element
//   s_tvalid      element valid
//   s_tready      element accepted when s_tvalid & s_tready
//   s_tlast       last element of a vector
//   m_x           packed vector, lane k at bits [k*DW +: DW]
//   m_x_valid     vector valid
//   m_x_ready     consumer ready
//   m_lanes_used  lanes holding real data, valid with m_x_valid
//   frame_err     one-cycle pulse on s_tlast / count mismatch
module fp16_vec64_packer
  import fp16_vec64_packer_pkg::*;
#(
  parameter  int unsigned    N_LANES   = MAX_LANES,
  parameter  int unsigned    DW        = FP16_DW,
  parameter  logic [DW-1:0]  PAD_VALUE = FP16_NEG_INF,
  localparam int unsigned    IW        = $clog2(N_LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [N_LANES*DW-1:0] m_x,
  output logic                  m_x_valid,
  input  logic                  m_x_ready,
  output logic [IW:0]           m_lanes_used,
  output logic                  frame_err
);

  logic [N_LANES-1:0][DW-1:0] lanes;
  logic                       wr_en;
  logic [IW-1:0]              wr_idx;
  logic [N_LANES-1:0]         pad_mask;

  fp16_pack_ctrl #(
    .N_LANES (N_LANES)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .m_x_ready  (m_x_ready),
    .s_tready   (s_tready),
    .m_x_valid  (m_x_valid),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .pad_mask   (pad_mask),
    .lanes_used (m_lanes_used),
    .frame_err  (frame_err)
  );

  // wr_en is only possible in COLLECT, so the held vector is never disturbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes <= '0;
    end else begin
      for (int unsigned k = 0; k < N_LANES; k++) begin
        if (wr_en && (wr_idx == IW'(k))) begin
          lanes[k] <= s_tdata;
        end else if (pad_mask[k]) begin
          lanes[k] <= PAD_VALUE;
        end
      end
    end
  end

  assign m_x = lanes;

endmodule

// File: tb/tb_fp16_vec64_packer.sv
module tb_fp16_vec64_packer;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_x_ready = 1'b0;
  logic          s_tready;
  logic [1023:0] m_x;
  logic          m_x_valid;
  logic [6:0]    m_lanes_used;
  logic          frame_err;

  fp16_vec64_packer dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .m_x          (m_x),
    .m_x_valid    (m_x_valid),
    .m_x_ready    (m_x_ready),
    .m_lanes_used (m_lanes_used),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: lane contents, elements taken in current vector, vector pending.
  logic [15:0] ref_lane [64];
  int          ref_cnt;
  bit          ref_pending;
  int          ref_used;
  bit          ref_ferr;
  int          vec_done;
  int          valid_seen;
  int          ferr_seen;
  int          total = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1023:0] ref_vec();
    logic [1023:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) v[k*16 +: 16] = ref_lane[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 64; k++) ref_lane[k] = 16'h0000;
    ref_cnt = 0;
    ref_pending = 0;
    ref_used = 0;
    ref_ferr = 0;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_x_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_m_x", m_x, 0);
    chk("rst_valid", m_x_valid, 0);
    chk("rst_lanes_used", m_lanes_used, 0);
    chk("rst_frame_err", frame_err, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [15:0] d, input bit lst, input bit rdy);
    bit acc;
    s_tvalid = v;
    s_tdata = d;
    s_tlast = lst;
    m_x_ready = rdy;
    #1;
    chk("s_tready", s_tready, !ref_pending);
    chk("valid_pre", m_x_valid, ref_pending);
    @(posedge clk);
    acc = v && !ref_pending;
    ref_ferr = 0;
    if (ref_pending) begin
      if (rdy) begin
        ref_pending = 0;
        ref_cnt = 0;
        vec_done++;
      end
    end else if (acc) begin
      ref_lane[ref_cnt] = d;
`ifdef FP16_PACK_PAD_EN
      ref_ferr = !lst && (ref_cnt == 63);
`else
      ref_ferr = (lst != (ref_cnt == 63));
`endif
      if (ref_cnt == 63) begin
        ref_used = 64;
        ref_pending = 1;
        ref_cnt = 0;
      end
`ifdef FP16_PACK_PAD_EN
      else if (lst) begin
        for (int k = ref_cnt + 1; k < 64; k++) ref_lane[k] = 16'hFC00;
        ref_used = ref_cnt + 1;
        ref_pending = 1;
        ref_cnt = 0;
      end
`endif
      else begin
        ref_cnt++;
      end
    end
    #1;
    chk("frame_err", frame_err, ref_ferr);
    chk("valid_post", m_x_valid, ref_pending);
    if (m_x_valid) valid_seen++;
    if (frame_err) ferr_seen++;
    if (ref_pending) begin
      chk("m_x", m_x, ref_vec());
      chk("lanes_used", m_lanes_used, ref_used);
    end
  endtask

  initial begin
    int fe0;
    bit v, lst, rdy;
    vec_done = 0;
    valid_seen = 0;
    ferr_seen = 0;
    model_reset();

    do_reset();

    // Incrementing pattern, consumer always ready.
    for (int k = 0; k < 64; k++) cycle(1'b1, 16'(16'h3C00 + k), k == 63, 1'b1);
    chk("t1_lane63", m_x[1023:1008], 16'h3C3F);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Consumer stalls while source keeps offering data.
    for (int k = 0; k < 64; k++) cycle(1'b1, 16'($urandom), k == 63, 1'b0);
    repeat (10) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
    cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
    chk("t2_lane0_next", m_x[15:0], 16'hABCD);
    for (int k = 1; k < 64; k++) cycle(1'b1, 16'($urandom), k == 63, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Early s_tlast on element 10.
    fe0 = ferr_seen;
`ifdef FP16_PACK_PAD_EN
    for (int k = 0; k <= 10; k++) cycle(1'b1, 16'($urandom), k == 10, 1'b1);
    chk("t3_pad_used", m_lanes_used, 11);
    chk("t3_pad_lane11", m_x[191:176], 16'hFC00);
    chk("t3_pad_lane63", m_x[1023:1008], 16'hFC00);
    chk("t3_pad_no_ferr", ferr_seen - fe0, 0);
`else
    for (int k = 0; k < 64; k++) cycle(1'b1, 16'($urandom), (k == 10) || (k == 63), 1'b1);
    chk("t3_ferr_once", ferr_seen - fe0, 1);
    chk("t3_used", m_lanes_used, 64);
`endif
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Reset mid-vector, then a fresh vector.
    for (int k = 0; k < 30; k++) cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
    do_reset();
    for (int k = 0; k < 64; k++) cycle(1'b1, 16'(16'h1000 + 3 * k), k == 63, 1'b1);
    chk("t4_lane0", m_x[15:0], 16'h1000);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // Random gaps and random consumer backpressure.
    vec_done = 0;
    for (int c = 0; c < 4000 && vec_done < 6; c++) begin
      v = 1'($urandom_range(0, 1));
      rdy = 1'($urandom_range(0, 1));
      lst = (ref_cnt == 63) || ($urandom_range(0, 31) == 0);
      cycle(v, 16'($urandom), lst, rdy);
    end
    chk("t5_budget", vec_done >= 6, 1);

    // Back-to-back throughput: one vector per 65 cycles.
    do_reset();
    valid_seen = 0;
    repeat (260) cycle(1'b1, 16'($urandom), ref_cnt == 63, 1'b1);
    chk("t6_period65", valid_seen, 4);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
